avm_test_master: RTL

- Avalon-MM initiator that exercises 8-bit register slaves such as the SOPC test register: write a pattern, read it back, compare, step to the next address.
- Started by a one-cycle command pulse; reports busy, done, error count and first failing address.
- Sits in the SOPC as a bring-up/self-test master ahead of CPU availability.
- Uses the codebase's active-low write/read strobes and active-high waitrequest_n (1 = slave ready).

---
 rtl/avm_test_pkg.sv | 17 +
 rtl/avm_test_pattern.sv | 20 ++
 rtl/avm_test_master.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/avm_test_pkg.sv
// Shared types and default sizes for the Avalon-MM register test master.
package avm_test_pkg;

  // Run sequencer states: idle, write phase, read-back phase, one-cycle finish.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WR   = 2'd1,
    RD   = 2'd2,
    FIN  = 2'd3
  } state_e;

  localparam int DEF_ADDR_W      = 8;
  localparam int DEF_DATA_W      = 8;
  localparam int DEF_CNT_W       = 8;
  localparam int DEF_TIMEOUT_CYC = 255;

endpackage

// File: rtl/avm_test_pattern.sv
// Test pattern generator: pattern(i) = seed + i, truncated to DATA_W.
// Purely combinational so a future read checker can share it.
module avm_test_pattern #(
  parameter int DATA_W = 8,
  parameter int IDX_W  = 8
) (
  input  logic [DATA_W-1:0] seed,
  input  logic [IDX_W-1:0]  index,
  output logic [DATA_W-1:0] pattern
);

  logic [DATA_W-1:0] index_ext;

  // Fit the index to the data width (wraps if the index is wider).
  always_comb begin
    index_ext = DATA_W'(index);
    pattern   = seed + index_ext;
  end

endmodule

// File: rtl/avm_test_master.sv
// Avalon-MM bring-up master: writes seed+i to base+i, reads it back,
// counts mismatches and records the first failing address.
// Optional stall abort enabled by defining AVM_TEST_MASTER_TIMEOUT_EN.
module avm_test_master
  import avm_test_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int CNT_W       = DEF_CNT_W,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic              csi_clockreset_clk,
  input  logic              csi_clockreset_reset_n,
  input  logic              cmd_start,
  input  logic [ADDR_W-1:0] cmd_base_addr,
  input  logic [CNT_W-1:0]  cmd_count,
  input  logic [DATA_W-1:0] cmd_seed,
  output logic              sts_busy,
  output logic              sts_done,
  output logic [CNT_W-1:0]  sts_err_count,
  output logic [ADDR_W-1:0] sts_first_err_addr,
  output logic              sts_timeout,
  output logic [ADDR_W-1:0] avm_address,
  output logic [DATA_W-1:0] avm_writedata,
  output logic              avm_write_n,
  output logic              avm_read_n,
  input  logic [DATA_W-1:0] avm_readdata,
  input  logic              avm_waitrequest_n
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  if (TIMEOUT_CYC < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYC must be at least 1");
  end

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [CNT_W-1:0]  index_q, index_d;
  logic [DATA_W-1:0] seed_q, seed_d;
  logic [CNT_W-1:0]  err_q, err_d;
  logic [ADDR_W-1:0] first_q, first_d;
  logic [ADDR_W-1:0] addr_cur;
  logic [DATA_W-1:0] pattern;

`ifdef AVM_TEST_MASTER_TIMEOUT_EN
  localparam int STALL_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [STALL_W-1:0] STALL_MAX = STALL_W'(TIMEOUT_CYC - 1);
  localparam logic [STALL_W-1:0] STALL_ONE = STALL_W'(1);
  logic [STALL_W-1:0] stall_q, stall_d;
  logic               timeout_q, timeout_d;
`endif

  avm_test_pattern #(
    .DATA_W(DATA_W),
    .IDX_W (CNT_W)
  ) u_pattern (
    .seed   (seed_q),
    .index  (index_q),
    .pattern(pattern)
  );

  assign addr_cur = base_q + ADDR_W'(index_q);

  // Next-state logic: command capture, write/read sequencing, mismatch tracking.
  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    count_d = count_q;
    index_d = index_q;
    seed_d  = seed_q;
    err_d   = err_q;
    first_d = first_q;
`ifdef AVM_TEST_MASTER_TIMEOUT_EN
    stall_d   = stall_q;
    timeout_d = timeout_q;
`endif
    case (state_q)
      IDLE: begin
        if (cmd_start) begin
          base_d  = cmd_base_addr;
          count_d = cmd_count;
          seed_d  = cmd_seed;
          index_d = '0;
          err_d   = '0;
          first_d = '0;
          state_d = (cmd_count == '0) ? FIN : WR;
        end
      end
      WR: begin
        if (avm_waitrequest_n) state_d = RD;
      end
      RD: begin
        if (avm_waitrequest_n) begin
          if (avm_readdata != pattern) begin
            if (err_q != '1) err_d = err_q + CNT_ONE;
            // err_q still zero means this is the first mismatch of the run
            if (err_q == '0) first_d = addr_cur;
          end
          if (index_q == count_q - CNT_ONE) begin
            state_d = FIN;
          end else begin
            index_d = index_q + CNT_ONE;
            state_d = WR;
          end
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
`ifdef AVM_TEST_MASTER_TIMEOUT_EN
    // Stall watchdog: restarts on every state change, aborts the run when full.
    if (state_q == IDLE && cmd_start) timeout_d = 1'b0;
    if ((state_q == WR || state_q == RD) && !avm_waitrequest_n) begin
      if (stall_q == STALL_MAX) begin
        state_d   = FIN;
        timeout_d = 1'b1;
        stall_d   = '0;
      end else begin
        stall_d = stall_q + STALL_ONE;
      end
    end else if (state_d != state_q) begin
      stall_d = '0;
    end
`endif
  end

  // State and run registers; reset returns everything to idle immediately.
  always_ff @(posedge csi_clockreset_clk or negedge csi_clockreset_reset_n) begin
    if (!csi_clockreset_reset_n) begin
      state_q <= IDLE;
      base_q  <= '0;
      count_q <= '0;
      index_q <= '0;
      seed_q  <= '0;
      err_q   <= '0;
      first_q <= '0;
`ifdef AVM_TEST_MASTER_TIMEOUT_EN
      stall_q   <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      count_q <= count_d;
      index_q <= index_d;
      seed_q  <= seed_d;
      err_q   <= err_d;
      first_q <= first_d;
`ifdef AVM_TEST_MASTER_TIMEOUT_EN
      stall_q   <= stall_d;
      timeout_q <= timeout_d;
`endif
    end
  end

  // Bus and status outputs decode straight from registered state, so they are
  // glitch-free and stay stable while the slave stalls.
  assign avm_write_n        = (state_q != WR);
  assign avm_read_n         = (state_q != RD);
  assign avm_address        = addr_cur;
  assign avm_writedata      = pattern;
  assign sts_busy           = (state_q == WR) || (state_q == RD);
  assign sts_done           = (state_q == FIN);
  assign sts_err_count      = err_q;
  assign sts_first_err_addr = first_q;
`ifdef AVM_TEST_MASTER_TIMEOUT_EN
  assign sts_timeout = timeout_q;
`else
  assign sts_timeout = 1'b0;
`endif

endmodule
